// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin FIFO arbiter.
package fifo_rr_arbiter_pkg;

    localparam logic [0:0] ARB_ROTATE = 1'b0;
    localparam logic [0:0] ARB_HOLD   = 1'b1;

    // Index width that stays at least one bit wide for tiny counts.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_pick.sv
// Rotating priority encoder: first set request at or after base_i, wrapping modulo NUM.
module fifo_rr_arbiter_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NUM = 4,
    localparam int IW = idx_w(NUM)
) (
    input  logic [NUM-1:0] req_i,
    input  logic [IW-1:0]  base_i,
    output logic [IW-1:0]  grant_o,
    output logic           any_o
);

    localparam logic [IW:0] NUM_V = (IW+1)'(NUM);

    logic [NUM-1:0] rot_req;
    logic [NUM-1:0] rot_oh;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Doubling the vector turns the modulo rotation into a plain shift.
    assign rot_req = NUM'({req_i, req_i} >> base_i);
    assign rot_oh  = rot_req & (~rot_req + NUM'(1));
    assign any_o   = |req_i;

    always_comb begin
        off = '0;
        for (int k = 0; k < NUM; k++) begin
            if (rot_oh[k]) off = off | IW'(k);
        end
    end

    assign sum     = {1'b0, base_i} + {1'b0, off};
    assign grant_o = (sum >= NUM_V) ? IW'(sum - NUM_V) : sum[IW-1:0];

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with bounded burst hold, merging NUM_SRC lookahead FIFOs
// into one lookahead FIFO port through a registered one-entry output stage.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 4,
    localparam int SW = idx_w(NUM_SRC),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            empty_i,
    output logic [NUM_SRC-1:0]            rd_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] dout_i,
    output logic                          empty,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic [SW-1:0]                 src
);

    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_SRC - 1);
    localparam logic [CW-1:0] BURST_V  = CW'(MAX_BURST);

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [SW-1:0]         last_q, last_d;
    logic                  empty_q, empty_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [SW-1:0]         src_q, src_d;

    logic [SW-1:0]         base;
    logic [SW-1:0]         rot_g;
    logic [SW-1:0]         g;
    logic                  any_req;
    logic                  hold_ok;
    logic                  load;
    logic [DATA_WIDTH-1:0] sel_data;

    assign base = (last_q == LAST_IDX) ? '0 : last_q + SW'(1);

    fifo_rr_arbiter_pick #(.NUM(NUM_SRC)) u_pick (
        .req_i   (~empty_i),
        .base_i  (base),
        .grant_o (rot_g),
        .any_o   (any_req)
    );

    assign hold_ok = (state_q == ARB_HOLD) && !empty_i[last_q];
    assign g       = hold_ok ? last_q : rot_g;
    assign load    = (empty_q | rd) & ~rst & any_req;

    always_comb begin
        rd_i     = '0;
        sel_data = '0;
        if (load) rd_i[g] = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (g == SW'(s)) sel_data = dout_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Burst accounting only advances when a word is actually taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cnt_inc = CW'(1);
        if (load) begin
            if (g == last_q && state_q == ARB_HOLD) cnt_inc = cnt_q + CW'(1);
            last_d = g;
            if (cnt_inc < BURST_V) begin
                state_d = ARB_HOLD;
                cnt_d   = cnt_inc;
            end else begin
                state_d = ARB_ROTATE;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        empty_d = empty_q;
        dout_d  = dout_q;
        src_d   = src_q;
        if (load) begin
            empty_d = 1'b0;
            dout_d  = sel_data;
            src_d   = g;
        end else if (rd && !empty_q) begin
            empty_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_ROTATE;
            cnt_q   <= '0;
            last_q  <= LAST_IDX;
            empty_q <= 1'b1;
            dout_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            empty_q <= empty_d;
            dout_q  <= dout_d;
            src_q   <= src_d;
        end
    end

    assign empty = empty_q;
    assign dout  = dout_q;
    assign src   = src_q;

endmodule
